dpsk_decode: RTL

Coherent DPSK demodulator and differential decoder: the receive-side counterpart of `dpsk_code`. It multiplies incoming 8-bit carrier samples by a locally generated reference sine from the same `Sin` table, integrates over one symbol period, and slices the sign to recover carrier phase. It then XORs each symbol's phase with the previous one to reconstruct the original serial bit stream. It sits after the sample source (ADC or loopback from the modulator) and feeds the serial data sink.

---
 rtl/dpsk_decode.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dpsk_decode.sv
// Coherent DPSK demodulator: correlates received samples with the reference sine
// over each symbol, slices the sign for absolute phase and differentially decodes bits.
module dpsk_decode #(
   parameter int SPS    = 50,
   parameter int ACC_W  = 24,
   parameter int THRESH = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] rx_sample,
   input  logic [7:0] ref_sin,
   input  logic       sym_sync,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       phase_out,
   output logic       low_conf
);

   localparam int               CNT_W    = (SPS > 2) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SPS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [17:0]      prod_q, prod_d;
   logic                    first_q, first_d;
   logic                    last_q, last_d;
   logic                    v_q, v_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    prev_phase_q, prev_phase_d;
   logic                    bit_out_q, bit_out_d;
   logic                    bit_valid_q, bit_valid_d;
   logic                    phase_q, phase_d;
   logic                    low_conf_q, low_conf_d;

   logic [CNT_W-1:0]        idx_s;
   logic signed [8:0]       rx_c_s;
   logic signed [8:0]       rf_c_s;
   logic signed [17:0]      prod_s;
   logic signed [ACC_W-1:0] sum_s;
   logic [ACC_W-1:0]        mag_s;

   // Magnitude of a two's-complement accumulator value, read as unsigned.
   function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-1:0] m;
      if (v[ACC_W-1]) begin
         m = ACC_W'(-v);
      end else begin
         m = ACC_W'(v);
      end
      return m;
   endfunction

   // State register: tracks whether a symbol sync has been seen since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: any qualified sync enters or stays in RUN.
   always_comb begin
      state_d = state_q;
      if (in_valid && sym_sync) begin
         state_d = RUN;
      end else begin
         state_d = state_q;
      end
   end

   // FSM output: sample index of the current input; sync realigns in either state.
   always_comb begin
      idx_s = cnt_q;
      case (state_q)
         IDLE:    idx_s = sym_sync ? CNT_ZERO : cnt_q;
         RUN:     idx_s = sym_sync ? CNT_ZERO : cnt_q;
         default: idx_s = cnt_q;
      endcase
   end

   // Stage 1: centre both inputs, multiply, and tag symbol boundaries.
   always_comb begin
      rx_c_s  = $signed({1'b0, rx_sample} - 9'd128);
      rf_c_s  = $signed({1'b0, ref_sin} - 9'd128);
      prod_s  = rx_c_s * rf_c_s;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      first_d = first_q;
      last_d  = last_q;
      v_d     = 1'b0;
      if (in_valid) begin
         prod_d  = prod_s;
         first_d = (idx_s == CNT_ZERO);
         // A sync on the would-be last sample already forced idx_s to 0.
         last_d  = (idx_s == LAST_IDX) && !sym_sync;
         v_d     = 1'b1;
         cnt_d   = (idx_s == LAST_IDX) ? CNT_ZERO : (idx_s + CNT_ONE);
      end else begin
         v_d     = 1'b0;
      end
   end

   // Stage 2: integrate, and on the last sample slice phase and decode the bit.
   always_comb begin
      sum_s        = (first_q ? {ACC_W{1'b0}} : acc_q)
                     + {{(ACC_W-18){prod_q[17]}}, prod_q};
      mag_s        = magnitude(sum_s);
      acc_d        = acc_q;
      prev_phase_d = prev_phase_q;
      bit_out_d    = bit_out_q;
      phase_d      = phase_q;
      low_conf_d   = low_conf_q;
      bit_valid_d  = 1'b0;
      if (v_q) begin
         acc_d = sum_s;
         if (last_q) begin
            phase_d      = sum_s[ACC_W-1];
            bit_out_d    = sum_s[ACC_W-1] ^ prev_phase_q;
            low_conf_d   = (mag_s < THRESH_V);
            prev_phase_d = sum_s[ACC_W-1];
            bit_valid_d  = 1'b1;
         end else begin
            bit_valid_d  = 1'b0;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Datapath registers, all cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= CNT_ZERO;
         prod_q       <= 18'sd0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         v_q          <= 1'b0;
         acc_q        <= {ACC_W{1'b0}};
         prev_phase_q <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         phase_q      <= 1'b0;
         low_conf_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         prod_q       <= prod_d;
         first_q      <= first_d;
         last_q       <= last_d;
         v_q          <= v_d;
         acc_q        <= acc_d;
         prev_phase_q <= prev_phase_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         phase_q      <= phase_d;
         low_conf_q   <= low_conf_d;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign phase_out = phase_q;
   assign low_conf  = low_conf_q;

endmodule
